// File: rtl/gamepad_source_mux.sv
// Merges SOURCES synchronised gamepad feeds; the last-pressed source drives the ics32 pad bus.
// Define GAMEPAD_MUX_MERGE_EN to OR all present sources instead of arbitrating.
module gamepad_source_mux #(
  parameter int SOURCES     = 3,
  parameter int PLAYERS     = 2,
  parameter int BUTTONS     = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SOURCES*PLAYERS*BUTTONS-1:0] src_btn,
  input  logic [SOURCES-1:0]                 src_present,
  input  logic                               pad_latch,
  input  logic                               pad_clk,
  output logic [PLAYERS-1:0]                 pad_data,
  output logic [2:0]                         active_src,
  output logic [BUTTONS-1:0]                 pad_btn_p0
);
  localparam int PB = PLAYERS*BUTTONS;
  localparam int NB = SOURCES*PB;

  logic [NB-1:0]      btn_sync_q  [SYNC_STAGES];
  logic [SOURCES-1:0] pres_sync_q [SYNC_STAGES];
  logic [SOURCES-1:0] pres_s;
  logic [NB-1:0]      btn_m;
  logic [BUTTONS-1:0] sel_d   [PLAYERS];
  logic [BUTTONS-1:0] sel_q   [PLAYERS];
  logic [BUTTONS-1:0] shift_d [PLAYERS];
  logic [BUTTONS-1:0] shift_q [PLAYERS];
  logic               pclk_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        btn_sync_q[i]  <= '0;
        pres_sync_q[i] <= '0;
      end
    end else begin
      btn_sync_q[0]  <= src_btn;
      pres_sync_q[0] <= src_present;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        btn_sync_q[i]  <= btn_sync_q[i-1];
        pres_sync_q[i] <= pres_sync_q[i-1];
      end
    end
  end

  assign pres_s = pres_sync_q[SYNC_STAGES-1];

  // An absent source contributes no buttons at all.
  always_comb begin
    btn_m = '0;
    for (int s = 0; s < SOURCES; s++) begin
      btn_m[s*PB +: PB] = btn_sync_q[SYNC_STAGES-1][s*PB +: PB]
                        & {PB{pres_s[s]}};
    end
  end

`ifdef GAMEPAD_MUX_MERGE_EN
  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      sel_d[p] = '0;
      for (int s = 0; s < SOURCES; s++) begin
        sel_d[p] = sel_d[p] | btn_m[(s*PLAYERS+p)*BUTTONS +: BUTTONS];
      end
    end
  end

  assign active_src = 3'd0;
`else
  logic [NB-1:0]      btn_prev_q;
  logic [SOURCES-1:0] press;
  logic [2:0]         act_d;
  logic [2:0]         act_q;
  logic               cur_ok;

  always_comb begin
    press = '0;
    for (int s = 0; s < SOURCES; s++) begin
      press[s] = |(btn_m[s*PB +: PB] & ~btn_prev_q[s*PB +: PB]);
    end
  end

  // A press elsewhere beats falling back after the active source drops.
  always_comb begin
    act_d  = act_q;
    cur_ok = 1'b0;
    for (int s = 0; s < SOURCES; s++) begin
      if (3'(s) == act_q) cur_ok = pres_s[s];
    end
    if (!cur_ok) begin
      act_d = 3'd0;
      for (int s = SOURCES-1; s >= 0; s--) begin
        if (pres_s[s]) act_d = 3'(s);
      end
    end
    for (int s = SOURCES-1; s >= 0; s--) begin
      if (press[s] && 3'(s) != act_q) act_d = 3'(s);
    end
  end

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      sel_d[p] = '0;
      for (int s = 0; s < SOURCES; s++) begin
        if (3'(s) == act_q) begin
          sel_d[p] = btn_m[(s*PLAYERS+p)*BUTTONS +: BUTTONS];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev_q <= '0;
      act_q      <= 3'd0;
    end else begin
      btn_prev_q <= btn_m;
      act_q      <= act_d;
    end
  end

  assign active_src = act_q;
`endif

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      shift_d[p] = shift_q[p];
      if (pad_latch) begin
        shift_d[p] = sel_q[p];
      end else if (pad_clk && !pclk_q) begin
        shift_d[p] = shift_q[p] >> 1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_q <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) begin
        sel_q[p]   <= '0;
        shift_q[p] <= '0;
      end
    end else begin
      pclk_q <= pad_clk;
      for (int p = 0; p < PLAYERS; p++) begin
        sel_q[p]   <= sel_d[p];
        shift_q[p] <= shift_d[p];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PLAYERS; p++) begin
      pad_data[p] = shift_q[p][0];
    end
  end

  assign pad_btn_p0 = sel_q[0];

endmodule

// File: tb/tb_gamepad_source_mux.sv
// Bench for gamepad_source_mux: directed scenarios plus randomized presses
// against an event-level model of last-pressed-source arbitration.
module tb_gamepad_source_mux;
  localparam int S  = 3;
  localparam int P  = 2;
  localparam int B  = 12;
  localparam int SS = 2;
  localparam int PB = P*B;
  localparam int NB = S*PB;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pad_latch = 1'b0;
  logic          pad_clk = 1'b0;
  logic [NB-1:0] src_btn = '0;
  logic [S-1:0]  src_present = '0;
  logic [P-1:0]  pad_data;
  logic [2:0]    active_src;
  logic [B-1:0]  pad_btn_p0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [NB-1:0] m_prev = '0;
  int            m_act = 0;

  always #5 clk = ~clk;

  gamepad_source_mux #(
    .SOURCES(S), .PLAYERS(P), .BUTTONS(B), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset), .src_btn(src_btn),
    .src_present(src_present), .pad_latch(pad_latch),
    .pad_clk(pad_clk), .pad_data(pad_data),
    .active_src(active_src), .pad_btn_p0(pad_btn_p0)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    repeat (SS + 4) tick();
  endtask

  task automatic pulse();
    pad_clk = 1'b1; tick();
    pad_clk = 1'b0; tick();
  endtask

  task automatic latch_pad();
    pad_latch = 1'b1; tick(); tick();
    pad_latch = 1'b0; tick();
  endtask

  function automatic logic [NB-1:0] eff_of(input logic [NB-1:0] b,
                                           input logic [S-1:0] pr);
    logic [NB-1:0] e;
    e = '0;
    for (int s = 0; s < S; s++)
      if (pr[s]) e[s*PB +: PB] = b[s*PB +: PB];
    return e;
  endfunction

  // Model: a source whose visible buttons gained any new bit is "pressed";
  // the lowest pressed source other than the current one takes over.
  task automatic drive(input logic [NB-1:0] b, input logic [S-1:0] pr);
    logic [NB-1:0] e;
    int pick;
    src_btn = b;
    src_present = pr;
    e = eff_of(b, pr);
    pick = -1;
    for (int s = S-1; s >= 0; s--)
      if (s != m_act && |(e[s*PB +: PB] & ~m_prev[s*PB +: PB])) pick = s;
    if (pick >= 0) m_act = pick;
    else if (!pr[m_act]) begin
      m_act = 0;
      for (int s = S-1; s >= 0; s--) if (pr[s]) m_act = s;
    end
`ifdef GAMEPAD_MUX_MERGE_EN
    m_act = 0;
`endif
    m_prev = e;
  endtask

  function automatic logic [B-1:0] exp_sel(input int p);
    logic [NB-1:0] e;
    logic [B-1:0] r;
    e = eff_of(src_btn, src_present);
    r = '0;
`ifdef GAMEPAD_MUX_MERGE_EN
    for (int s = 0; s < S; s++) r = r | e[(s*P+p)*B +: B];
`else
    r = e[(m_act*P+p)*B +: B];
`endif
    return r;
  endfunction

  function automatic logic [PB-1:0] exp_frame();
    logic [PB-1:0] f;
    for (int p = 0; p < P; p++) f[p*B +: B] = exp_sel(p);
    return f;
  endfunction

  function automatic logic [NB-1:0] btn_at(input int s, input int p,
                                           input logic [B-1:0] v);
    logic [NB-1:0] r;
    r = '0;
    r[(s*P+p)*B +: B] = v;
    return r;
  endfunction

  task automatic do_reset(input logic [NB-1:0] b, input logic [S-1:0] pr);
    src_btn = b;
    src_present = pr;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    m_act = 0;
    m_prev = '0;
    drive(b, pr);
    settle();
  endtask

  task automatic test_reset();
    src_btn = '1; src_present = '1;
    reset = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (pad_data !== '0 || active_src !== 3'd0 || pad_btn_p0 !== '0) begin
      n_bad++;
      $display("FAIL reset: data=%b act=%0d btn=%h want 0/0/0",
               pad_data, active_src, pad_btn_p0);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic_read();
    logic [PB-1:0] f;
    logic [B-1:0] old;
    logic ex;
    do_reset(btn_at(0, 0, 12'h005), 3'b001);
    n_cmp++;
    if (pad_btn_p0 !== exp_sel(0) || active_src !== 3'(m_act)) begin
      n_bad++;
      $display("FAIL basic_state: btn=%h act=%0d want %h/%0d",
               pad_btn_p0, active_src, exp_sel(0), m_act);
    end
    f = exp_frame();
    latch_pad();
    for (int i = 0; i < B + 2; i++) begin
      if (i > 0) pulse();
      for (int p = 0; p < P; p++) begin
        ex = (i < B) ? f[p*B + i] : 1'b0;
        n_cmp++;
        if (pad_data[p] !== ex) begin
          n_bad++;
          $display("FAIL basic_read p%0d bit%0d: got %b want %b",
                   p, i, pad_data[p], ex);
        end
      end
    end
    old = exp_sel(0);
    drive(src_btn | btn_at(0, 0, 12'h030), src_present);
    repeat (SS) tick();
    n_cmp++;
    if (pad_btn_p0 !== old) begin
      n_bad++;
      $display("FAIL btn_latency_early: got %h want %h", pad_btn_p0, old);
    end
    tick();
    n_cmp++;
    if (pad_btn_p0 !== exp_sel(0)) begin
      n_bad++;
      $display("FAIL btn_latency: got %h want %h", pad_btn_p0, exp_sel(0));
    end
  endtask

  task automatic test_switch();
    int old_act;
    logic [PB-1:0] f;
    logic ex;
    do_reset(btn_at(0, 0, 12'h001), 3'b101);
    old_act = m_act;
    drive(src_btn | btn_at(2, 0, 12'h800), 3'b101);
    repeat (SS) tick();
    n_cmp++;
    if (active_src !== 3'(old_act)) begin
      n_bad++;
      $display("FAIL switch_early: act=%0d want %0d", active_src, old_act);
    end
    tick();
    n_cmp++;
    if (active_src !== 3'(m_act)) begin
      n_bad++;
      $display("FAIL switch_latency: act=%0d want %0d", active_src, m_act);
    end
    settle();
    f = exp_frame();
    latch_pad();
    for (int i = 0; i < B; i++) begin
      if (i > 0) pulse();
      ex = f[i];
      n_cmp++;
      if (pad_data[0] !== ex) begin
        n_bad++;
        $display("FAIL switch_read bit%0d: got %b want %b", i, pad_data[0], ex);
      end
    end
  endtask

  task automatic test_simultaneous();
    do_reset('0, 3'b111);
    drive(btn_at(1, 1, 12'h008) | btn_at(2, 0, 12'h001), 3'b111);
    settle();
    n_cmp++;
    if (active_src !== 3'(m_act) || pad_btn_p0 !== exp_sel(0)) begin
      n_bad++;
      $display("FAIL simultaneous: act=%0d btn=%h want %0d/%h",
               active_src, pad_btn_p0, m_act, exp_sel(0));
    end
  endtask

  task automatic test_midread_switch();
    logic [PB-1:0] f;
    logic ex;
    do_reset(btn_at(0, 0, 12'hA5C) | btn_at(0, 1, 12'h3F1), 3'b111);
    f = exp_frame();
    latch_pad();
    for (int i = 0; i < B + 2; i++) begin
      if (i > 0) pulse();
      if (i == 5) begin
        pulse();
        drive(src_btn | btn_at(1, 0, 12'h0F0) | btn_at(1, 1, 12'h00F),
              src_present);
        settle();
        i = i;
      end
      for (int p = 0; p < P; p++) begin
        ex = (i < B) ? f[p*B + i] : 1'b0;
        if (i == 5) ex = f[p*B + 6];
        n_cmp++;
        if (pad_data[p] !== ex) begin
          n_bad++;
          $display("FAIL midread_old p%0d pos%0d: got %b want %b",
                   p, i, pad_data[p], ex);
        end
      end
      if (i == 5) i = 6;
    end
    n_cmp++;
    if (active_src !== 3'(m_act)) begin
      n_bad++;
      $display("FAIL midread_act: act=%0d want %0d", active_src, m_act);
    end
    f = exp_frame();
    latch_pad();
    for (int i = 0; i < B; i++) begin
      if (i > 0) pulse();
      for (int p = 0; p < P; p++) begin
        n_cmp++;
        if (pad_data[p] !== f[p*B + i]) begin
          n_bad++;
          $display("FAIL midread_new p%0d bit%0d: got %b want %b",
                   p, i, pad_data[p], f[p*B + i]);
        end
      end
    end
  endtask

  task automatic test_latch_edge();
    logic [PB-1:0] f;
    logic ex;
    do_reset(btn_at(0, 0, 12'h5A5) | btn_at(0, 1, 12'h6B6), 3'b001);
    f = exp_frame();
    pad_latch = 1'b1; tick(); tick();
    pad_clk = 1'b1; tick();
    pad_latch = 1'b0; tick();
    pad_clk = 1'b0; tick();
    for (int i = 0; i < B + 3; i++) begin
      if (i > 0) pulse();
      for (int p = 0; p < P; p++) begin
        ex = (i < B) ? f[p*B + i] : 1'b0;
        n_cmp++;
        if (pad_data[p] !== ex) begin
          n_bad++;
          $display("FAIL latch_edge p%0d bit%0d: got %b want %b",
                   p, i, pad_data[p], ex);
        end
      end
    end
  endtask

  task automatic test_drop();
    do_reset(btn_at(0, 0, 12'h001), 3'b101);
    drive(src_btn | btn_at(2, 0, 12'h800), 3'b101);
    settle();
    drive(src_btn, 3'b001);
    settle();
    n_cmp++;
    if (active_src !== 3'(m_act) || pad_btn_p0 !== exp_sel(0)) begin
      n_bad++;
      $display("FAIL drop: act=%0d btn=%h want %0d/%h",
               active_src, pad_btn_p0, m_act, exp_sel(0));
    end
    drive(btn_at(0, 0, 12'h001) | btn_at(1, 0, 12'h100), 3'b011);
    settle();
    n_cmp++;
    if (pad_btn_p0 !== exp_sel(0) || active_src !== 3'(m_act)) begin
      n_bad++;
      $display("FAIL merge_or: btn=%h act=%0d want %h/%0d",
               pad_btn_p0, active_src, exp_sel(0), m_act);
    end
  endtask

  task automatic test_reset_midread();
    logic [PB-1:0] f;
    do_reset(btn_at(1, 0, 12'hFFF) | btn_at(0, 1, 12'h001), 3'b011);
    latch_pad();
    pulse();
    reset = 1'b1; tick();
    n_cmp++;
    if (pad_data !== '0 || active_src !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_midread: data=%b act=%0d want 0/0",
               pad_data, active_src);
    end
    reset = 1'b0;
    m_act = 0;
    m_prev = '0;
    drive(src_btn, src_present);
    settle();
    f = exp_frame();
    latch_pad();
    for (int i = 0; i < B; i++) begin
      if (i > 0) pulse();
      for (int p = 0; p < P; p++) begin
        n_cmp++;
        if (pad_data[p] !== f[p*B + i]) begin
          n_bad++;
          $display("FAIL reset_reread p%0d bit%0d: got %b want %b",
                   p, i, pad_data[p], f[p*B + i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] b;
    logic [S-1:0] pr;
    logic [PB-1:0] f;
    do_reset('0, 3'b111);
    for (int it = 0; it < 40; it++) begin
      b = src_btn;
      pr = src_present;
      if ($urandom_range(3, 0) == 0) pr = S'($urandom_range(7, 0));
      repeat ($urandom_range(2, 1)) b[$urandom_range(NB-1, 0)] ^= 1'b1;
      if ($urandom_range(5, 0) == 0) b[$urandom_range(S-1, 0)*PB +: PB] = '0;
      drive(b, pr);
      settle();
      n_cmp++;
      if (active_src !== 3'(m_act) || pad_btn_p0 !== exp_sel(0)) begin
        n_bad++;
        $display("FAIL random%0d: act=%0d btn=%h want %0d/%h",
                 it, active_src, pad_btn_p0, m_act, exp_sel(0));
      end
      if (it % 4 == 0) begin
        f = exp_frame();
        latch_pad();
        for (int i = 0; i < B + 1; i++) begin
          if (i > 0) pulse();
          for (int p = 0; p < P; p++) begin
            n_cmp++;
            if (pad_data[p] !== ((i < B) ? f[p*B + i] : 1'b0)) begin
              n_bad++;
              $display("FAIL random_read%0d p%0d bit%0d: got %b", it, p, i,
                       pad_data[p]);
            end
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_switch();
    test_simultaneous();
    test_midread_switch();
    test_latch_edge();
    test_drop();
    test_reset_midread();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
